// File: rtl/pc_unit.sv
// Program counter with TRAP > RET > REDIRECT > STALL > PC+4 next-PC priority.
// Define PC_UNIT_RAS_EN to compile in the circular return-address stack.
module pc_unit #(
  parameter int              SIZE       = 32,
  parameter logic [SIZE-1:0] RESET_ADDR = SIZE'(32'h0000_0000),
  parameter logic [SIZE-1:0] TRAP_VEC   = SIZE'(32'h0000_0100),
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic            CALL,
  input  logic            RET,
  input  logic            TRAP,
  input  logic [SIZE-1:0] TARGET,
  output logic [SIZE-1:0] PC,
  output logic [SIZE-1:0] PC_PLUS4,
  output logic            MISALIGNED,
  output logic            RAS_EMPTY
);

  logic [SIZE-1:0] pc_next;
  logic            mis_next;
  logic [SIZE-1:0] target_aligned;

  assign PC_PLUS4       = PC + SIZE'(4);
  assign target_aligned = {TARGET[SIZE-1:2], 2'b00};

`ifdef PC_UNIT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SIZE-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] push_idx;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign RAS_EMPTY = (count == '0);
  // A simultaneous pop and push rewrites the current top in place.
  assign push_idx  = pop ? top_ptr : top_ptr + 1'b1;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_call;

  assign unused_call = CALL;
  assign RAS_EMPTY   = 1'b1;
`endif

  always_comb begin
    pc_next  = PC_PLUS4;
    mis_next = 1'b0;
`ifdef PC_UNIT_RAS_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    if (TRAP) begin
      pc_next = TRAP_VEC;
`ifdef PC_UNIT_RAS_EN
    end else if (RET && !RAS_EMPTY) begin
      pc_next = ras_mem[top_ptr];
      pop     = 1'b1;
      push    = REDIRECT && CALL;
`endif
    end else if (RET || REDIRECT) begin
      // An empty-stack return falls back to TARGET like a plain redirect.
      pc_next  = target_aligned;
      mis_next = |TARGET[1:0];
`ifdef PC_UNIT_RAS_EN
      push     = REDIRECT && CALL;
`endif
    end else if (STALL) begin
      pc_next = PC;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PC         <= RESET_ADDR;
      MISALIGNED <= 1'b0;
    end else begin
      PC         <= pc_next;
      MISALIGNED <= mis_next;
    end
  end

`ifdef PC_UNIT_RAS_EN
  // Pointer wraps naturally, so a push onto a full stack lands on the oldest slot.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push && !pop) begin
      top_ptr <= top_ptr + 1'b1;
      if (count != CNT_W'(RAS_DEPTH)) count <= count + 1'b1;
    end else if (pop && !push) begin
      top_ptr <= top_ptr - 1'b1;
      count   <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && RESET_N) ras_mem[push_idx] <= PC_PLUS4;
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a queue-based reference model; honours PC_UNIT_RAS_EN like the DUT.
module tb_pc_unit;

  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          RAS_DEPTH = 4;

  logic        CLK      = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        STALL    = 1'b0;
  logic        REDIRECT = 1'b0;
  logic        CALL     = 1'b0;
  logic        RET      = 1'b0;
  logic        TRAP     = 1'b0;
  logic [31:0] TARGET   = '0;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        MISALIGNED;
  logic        RAS_EMPTY;

  logic       stall8    = 1'b0;
  logic       redirect8 = 1'b0;
  logic       call8     = 1'b0;
  logic       ret8      = 1'b0;
  logic       trap8     = 1'b0;
  logic [7:0] target8   = '0;
  logic [7:0] pc8;
  logic [7:0] pc_plus4_8;
  logic       misaligned8;
  logic       ras_empty8;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc  = '0;
  logic        m_mis = 1'b0;
  logic [31:0] m_ras [$];

  pc_unit #(
    .SIZE(32), .RESET_ADDR(32'h0), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(RAS_DEPTH)
  ) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .REDIRECT(REDIRECT), .CALL(CALL),
    .RET(RET), .TRAP(TRAP), .TARGET(TARGET), .PC(PC), .PC_PLUS4(PC_PLUS4),
    .MISALIGNED(MISALIGNED), .RAS_EMPTY(RAS_EMPTY)
  );

  pc_unit #(
    .SIZE(8), .RESET_ADDR(8'h00), .TRAP_VEC(8'h80), .RAS_DEPTH(2)
  ) u_dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(stall8), .REDIRECT(redirect8), .CALL(call8),
    .RET(ret8), .TRAP(trap8), .TARGET(target8), .PC(pc8), .PC_PLUS4(pc_plus4_8),
    .MISALIGNED(misaligned8), .RAS_EMPTY(ras_empty8)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic rasPush(input logic [31:0] addr);
    m_ras.push_back(addr);
    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
  endtask

  // Reference next state straight from the priority rules, using a plain queue as the stack.
  task automatic modelStep();
    logic [31:0] pc4;
    logic [31:0] tgt;
    pc4 = m_pc + 32'd4;
    tgt = TARGET & 32'hFFFF_FFFC;
    if (TRAP) begin
      m_pc  = TRAP_VEC;
      m_mis = 1'b0;
`ifdef PC_UNIT_RAS_EN
    end else if (RET && m_ras.size() > 0) begin
      m_pc  = m_ras.pop_back();
      m_mis = 1'b0;
      if (REDIRECT && CALL) rasPush(pc4);
`endif
    end else if (RET || REDIRECT) begin
      m_pc  = tgt;
      m_mis = (TARGET[1:0] != 2'b00);
`ifdef PC_UNIT_RAS_EN
      if (REDIRECT && CALL) rasPush(pc4);
`endif
    end else if (STALL) begin
      m_mis = 1'b0;
    end else begin
      m_pc  = pc4;
      m_mis = 1'b0;
    end
  endtask

  task automatic checkAll(input string tag);
    logic exp_empty;
`ifdef PC_UNIT_RAS_EN
    exp_empty = (m_ras.size() == 0);
`else
    exp_empty = 1'b1;
`endif
    checkOutput({tag, ".pc"}, PC, m_pc);
    checkOutput({tag, ".pc_plus4"}, PC_PLUS4, m_pc + 32'd4);
    checkOutput({tag, ".misaligned"}, {31'b0, MISALIGNED}, {31'b0, m_mis});
    checkOutput({tag, ".ras_empty"}, {31'b0, RAS_EMPTY}, {31'b0, exp_empty});
  endtask

  task automatic applyStimulus(input logic st, input logic rd, input logic cl, input logic rt,
                               input logic tp, input logic [31:0] tg, input string tag);
    STALL = st; REDIRECT = rd; CALL = cl; RET = rt; TRAP = tp; TARGET = tg;
    modelStep();
    @(posedge CLK);
    #1;
    checkAll(tag);
  endtask

  // Called 1 time unit after an edge; reset pulse lies entirely between edges.
  task automatic asyncReset();
    #2 RESET_N = 1'b0;
    #1;
    m_pc  = '0;
    m_mis = 1'b0;
    m_ras.delete();
    checkAll("async_reset");
    #1 RESET_N = 1'b1;
  endtask

  task automatic step8(input logic st, input logic rd, input logic rt, input logic tp, input logic [7:0] tg);
    stall8 = st; redirect8 = rd; ret8 = rt; trap8 = tp; target8 = tg; call8 = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] tgt;
`ifdef PC_UNIT_RAS_EN
    logic [31:0] exp_ret [5];
`endif
    #3;
    checkAll("reset");
    checkOutput("reset.pc8", {24'b0, pc8}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'h0, "seq");
      checkOutput("seq.const", PC, 32'(4 * i));
    end

    applyStimulus(1, 1, 0, 0, 0, 32'h103, "stall_redir");
    checkOutput("mis.pc", PC, 32'h100);
    checkOutput("mis.flag", {31'b0, MISALIGNED}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, "after_mis");
    checkOutput("mis.clear", {31'b0, MISALIGNED}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, "stall");
    checkOutput("stall.hold", PC, 32'h104);

    applyStimulus(0, 1, 0, 0, 0, 32'hFFFF_FFFC, "wrap_load");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, "wrap");
    checkOutput("wrap.const", PC, 32'h0);

`ifdef PC_UNIT_RAS_EN
    applyStimulus(0, 1, 0, 0, 0, 32'h10, "to10");
    applyStimulus(0, 1, 1, 0, 0, 32'h200, "call");
    checkOutput("call.pc", PC, 32'h200);
    checkOutput("call.empty", {31'b0, RAS_EMPTY}, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 32'h0, "ret");
    checkOutput("ret.pc", PC, 32'h14);
    checkOutput("ret.empty", {31'b0, RAS_EMPTY}, 32'h1);

    applyStimulus(0, 1, 0, 0, 0, 32'h0, "to0");
    for (int k = 1; k <= 5; k++) applyStimulus(0, 1, 1, 0, 0, 32'(4 * k), "call5");
    applyStimulus(1, 0, 0, 1, 1, 32'h0, "trap_full");
    checkOutput("trap.pc", PC, TRAP_VEC);
    checkOutput("trap.empty", {31'b0, RAS_EMPTY}, 32'h0);
    exp_ret = '{32'h14, 32'h10, 32'hC, 32'h8, 32'h900};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'h900, "ret5");
      checkOutput("ret5.const", PC, exp_ret[k]);
    end
`else
    applyStimulus(0, 1, 1, 0, 0, 32'h80, "call_nostack");
    applyStimulus(0, 0, 0, 1, 0, 32'h40, "ret_nostack");
    checkOutput("ret.pc", PC, 32'h40);
    checkOutput("ret.empty", {31'b0, RAS_EMPTY}, 32'h1);
    applyStimulus(1, 0, 0, 1, 1, 32'h0, "trap");
    checkOutput("trap.pc", PC, TRAP_VEC);
`endif

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) tgt = $urandom();
      else tgt = $urandom() & 32'h0000_0FFF;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, tgt, "rand");
      if ($urandom_range(0, 99) == 0) asyncReset();
    end

    applyStimulus(0, 0, 0, 0, 0, 32'h0, "idle");
    step8(0, 1, 0, 0, 8'hFC);
    checkOutput("w8.load", {24'b0, pc8}, 32'hFC);
    checkOutput("w8.plus4", {24'b0, pc_plus4_8}, 32'h00);
    step8(0, 0, 0, 0, 8'h00);
    checkOutput("w8.wrap", {24'b0, pc8}, 32'h00);
    step8(1, 0, 1, 1, 8'h44);
    checkOutput("w8.trap", {24'b0, pc8}, 32'h80);
    checkOutput("w8.empty", {31'b0, ras_empty8}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL take parameter SIZE, default 32, meaning PC width in bits (min 8).
REQ-002 The block SHALL take parameter RESET_ADDR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL take parameter TRAP_VEC, default 32'h0000_0100, meaning the PC value loaded on trap.
REQ-004 The block SHALL take parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, 2..16).
REQ-005 CLK  input  1  system clock, all state updates on rising edge.
REQ-006 RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 STALL  input  1  hold PC and stack this cycle.
REQ-008 REDIRECT  input  1  branch/jump taken; load TARGET.
REQ-009 CALL  input  1  qualifies REDIRECT as a call; push return address.
REQ-010 RET  input  1  return request; pop stack top.
REQ-011 TRAP  input  1  load TRAP_VEC.
REQ-012 TARGET  input  SIZE  redirect/fallback target address.
REQ-013 PC  output  SIZE  current program counter (registered).
REQ-014 PC_PLUS4  output  SIZE  combinational PC+4, modulo 2^SIZE.
REQ-015 MISALIGNED  output  1  registered one-cycle pulse: last loaded target had bits [1:0] nonzero.
REQ-016 RAS_EMPTY  output  1  stack holds zero valid entries.

Function
REQ-017 Next-PC priority SHALL be TRAP > RET > REDIRECT > STALL > sequential (PC+4).
- TRAP and REDIRECT/RET SHALL override STALL (flush semantics).
REQ-018 Sequential advance SHALL load PC+4, wrapping 2^SIZE-4 -> 0 with no flag.
REQ-019 STALL alone SHALL hold PC, stack, count and clear MISALIGNED.
REQ-020 REDIRECT SHALL load TARGET with bits [1:0] forced to 0; MISALIGNED SHALL be 1 the following cycle iff TARGET[1:0] != 0.
REQ-021 REDIRECT with CALL SHALL push PC_PLUS4 onto the stack in the same edge as the PC load.
REQ-022 CALL without REDIRECT SHALL be ignored.
REQ-023 Push when count == RAS_DEPTH SHALL overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
REQ-024 RET with stack non-empty SHALL load the stack top into PC and decrement count; RET with stack empty SHALL load TARGET per REQ-020.
REQ-025 RET and REDIRECT+CALL in the same cycle SHALL load the popped top into PC and replace that top with PC_PLUS4; count unchanged.
REQ-026 TRAP SHALL load TRAP_VEC, leave stack and count unchanged, and clear MISALIGNED.
REQ-027 Output latency: PC reflects any request on the edge after it is sampled; PC_PLUS4 follows PC combinationally.

Reset
REQ-028 RESET_N low SHALL asynchronously set PC = RESET_ADDR, count = 0, MISALIGNED = 0, RAS_EMPTY = 1.
REQ-029 Stack entry storage SHALL NOT require reset.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight push/pop; first edge after release SHALL advance PC to RESET_ADDR+4 unless a request is present.

Configuration
REQ-031 Macro PC_UNIT_RAS_EN SHALL compile the return-address stack in.
- Defined: REQ-021..REQ-025 apply.
- Undefined: no stack storage; CALL ignored; RET behaves exactly as REDIRECT to TARGET; RAS_EMPTY tied to 1.

Verification
REQ-032 Reset release, no requests, 3 edges -> PC = 0x0, 0x4, 0x8, 0xC.
REQ-033 PC=0x10, REDIRECT+CALL TARGET=0x200, then RET TARGET=0x0 -> PC = 0x200, then 0x14; RAS_EMPTY 1->0->1.
REQ-034 Push 5 calls with RAS_DEPTH=4 (returns 0x4,0x8,0xC,0x10,0x14), then 5 RETs with TARGET=0x900 -> PC = 0x14, 0x10, 0xC, 0x8, 0x900.
REQ-035 STALL=1 with REDIRECT TARGET=0x103 -> PC = 0x100, MISALIGNED = 1 next cycle only.
REQ-036 SIZE=8, PC=0xFC, no request -> PC = 0x00; TRAP with STALL and RET asserted -> PC = TRAP_VEC, count unchanged.
REQ-037 Macro undefined: RET TARGET=0x40 after a CALL -> PC = 0x40, RAS_EMPTY stays 1.
